// File: rtl/dmem_bank_arbiter_if.sv
// Request/grant bundle between one DMem_TPU bank arbiter and its three requesters.
// The TPU below is index 0, the TPU above is index 1, and the router is always the top index.
interface dmem_bank_arbiter_if #(
  parameter int NUM_REQ = 3
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] I_Req;
  logic [NUM_REQ-1:0] I_Rls;
  logic [NUM_REQ-1:0] O_Grant;
  logic               O_Ready;
  logic [OW-1:0]      O_Owner;
  logic [NUM_REQ-1:0] O_Revoke;
  logic               O_Timeout;

  modport slave (
    input  I_Req, I_Rls,
    output O_Grant, O_Ready, O_Owner, O_Revoke, O_Timeout
  );

  modport master (
    output I_Req, I_Rls,
    input  O_Grant, O_Ready, O_Owner, O_Revoke, O_Timeout
  );
endinterface

// File: rtl/dmem_bank_arbiter.sv
// Locked, exclusive grant of one DMem_TPU bank to the lower TPU, the upper TPU or the router.
// It applies router priority with a burst limit, round-robin fallback, and a hold-timeout revoke.
module dmem_bank_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MAX_HOLD    = 64,
  parameter int ROUTER_PRIO = 1,
  parameter int PRIO_BURST  = 4
) (
  input logic                clock,
  input logic                reset,
  dmem_bank_arbiter_if.slave arb
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 2);
  localparam int BW = $clog2(PRIO_BURST + 2);
  localparam logic [OW-1:0]      ROUTER_IDX = OW'(NUM_REQ - 1);
  localparam logic [HW-1:0]      HOLD_MAX   = HW'(MAX_HOLD);
  localparam logic [BW-1:0]      BURST_MAX  = BW'(PRIO_BURST);
  localparam logic [NUM_REQ-1:0] ROUTER_BIT = {1'b1, {(NUM_REQ-1){1'b0}}};
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_ready;
  logic [OW-1:0]      r_owner;
  logic [NUM_REQ-1:0] r_revoke;
  logic               r_timeout;
  logic [OW-1:0]      r_ptr;
  logic [HW-1:0]      r_hold;
  logic [BW-1:0]      r_burst;

  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [OW-1:0]      w_owner_nxt;
  logic [NUM_REQ-1:0] w_revoke_nxt;
  logic               w_timeout_nxt;
  logic [OW-1:0]      w_ptr_nxt;
  logic [HW-1:0]      w_hold_nxt;
  logic [BW-1:0]      w_burst_nxt;

  logic               w_tpu_pend;
  logic               w_burst_block;
  logic               w_prio_win;
  logic [NUM_REQ-1:0] w_rr_req;
  logic               w_rr_found;
  logic [OW-1:0]      w_rr_idx;
  logic [OW-1:0]      w_win_idx;
  logic               w_others_wait;

  // Winner selection: router priority unless its burst is spent, else round-robin after r_ptr.
  always_comb begin
    int v_idx;
    w_tpu_pend    = |(arb.I_Req & ~ROUTER_BIT);
    w_burst_block = (r_burst == BURST_MAX) && w_tpu_pend;
    w_prio_win    = (ROUTER_PRIO != 0) && arb.I_Req[NUM_REQ-1] && !w_burst_block;
    if ((ROUTER_PRIO != 0) && w_burst_block) begin
      w_rr_req = arb.I_Req & ~ROUTER_BIT;
    end else begin
      w_rr_req = arb.I_Req;
    end
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    // Walk offsets downwards so the nearest requester after the pointer is the one kept.
    for (int i = NUM_REQ; i >= 1; i--) begin
      v_idx = (int'(r_ptr) + i) % NUM_REQ;
      if (w_rr_req[v_idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = OW'(v_idx);
      end else begin
        w_rr_found = w_rr_found;
      end
    end
    w_win_idx     = w_prio_win ? ROUTER_IDX : w_rr_idx;
    w_others_wait = |(arb.I_Req & ~r_grant);
  end

  // Next-state and next-output logic of the IDLE/BUSY/RELEASE controller.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_revoke_nxt  = {NUM_REQ{1'b0}};
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_burst_nxt   = r_burst;
    case (r_state)
      ST_IDLE: begin
        if (w_prio_win || w_rr_found) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = ONE_HOT0 << w_win_idx;
          w_owner_nxt = w_win_idx;
          w_hold_nxt  = HW'(1);
          if (w_prio_win) begin
            w_burst_nxt = w_tpu_pend ? (r_burst + BW'(1)) : {BW{1'b0}};
          end else begin
            w_ptr_nxt = w_win_idx;
            if ((w_win_idx != ROUTER_IDX) || !w_tpu_pend) begin
              w_burst_nxt = {BW{1'b0}};
            end else begin
              w_burst_nxt = r_burst;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_hold_nxt = (r_hold < HOLD_MAX) ? (r_hold + HW'(1)) : r_hold;
        // A release in the same cycle as an expiring hold wins and suppresses the revoke.
        if (arb.I_Rls[r_owner]) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = {NUM_REQ{1'b0}};
        end else if ((MAX_HOLD != 0) && (r_hold == HOLD_MAX) && w_others_wait) begin
          w_state_nxt   = ST_RELEASE;
          w_grant_nxt   = {NUM_REQ{1'b0}};
          w_revoke_nxt  = r_grant;
          w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {NUM_REQ{1'b0}};
        w_hold_nxt  = {HW{1'b0}};
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {NUM_REQ{1'b0}};
        w_hold_nxt  = {HW{1'b0}};
      end
    endcase
  end

  // State, registered outputs, pointer and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= {NUM_REQ{1'b0}};
      r_ready   <= 1'b1;
      r_owner   <= {OW{1'b0}};
      r_revoke  <= {NUM_REQ{1'b0}};
      r_timeout <= 1'b0;
      r_ptr     <= ROUTER_IDX;
      r_hold    <= {HW{1'b0}};
      r_burst   <= {BW{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_owner   <= w_owner_nxt;
      r_revoke  <= w_revoke_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_burst   <= w_burst_nxt;
    end
  end

  assign arb.O_Grant   = r_grant;
  assign arb.O_Ready   = r_ready;
  assign arb.O_Owner   = r_owner;
  assign arb.O_Revoke  = r_revoke;
  assign arb.O_Timeout = r_timeout;
endmodule
